// File: rtl/irq_rr_scheduler.sv
// Round-robin interrupt scheduler: sticky pending bits, per-source
// enable mask, one grant at a time, released by done or by a service timeout.
module irq_rr_scheduler #(
  parameter int NINTR   = 4,
  parameter int IDW     = $clog2(NINTR),
  parameter int TIMEOUT = 16,
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NINTR-1:0] req,
  input  logic [NINTR-1:0] mask,
  input  logic             done,
  output logic             irq,
  output logic [IDW-1:0]   irq_id,
  output logic [NINTR-1:0] grant,
  output logic [NINTR-1:0] pending,
  output logic             timeout
);

  localparam int CW = (TW > 0) ? TW : 1;
  localparam logic [NINTR-1:0] ONE = NINTR'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e           state_q;
  logic [NINTR-1:0] pending_q;
  logic [NINTR-1:0] pending_d;
  logic [NINTR-1:0] grant_q;
  logic [IDW-1:0]   irq_id_q;
  logic [IDW-1:0]   ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             irq_q;
  logic             timeout_q;

  logic [NINTR-1:0] elig;
  logic [NINTR-1:0] clr;
  logic [IDW-1:0]   pick;
  logic             done_acc;
  logic             tmo_hit;

  assign done_acc = (state_q == SERVICE) && done;
  assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  assign clr      = done_acc ? grant_q : '0;
  // Set wins over clear so a request on the done edge re-pends.
  assign pending_d = (pending_q & ~clr) | req;
  assign elig      = pending_q & mask;

  // Scan farthest-first so the nearest candidate after ptr wins.
  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    pick = '0;
    idx  = 0;
    cand = '0;
    for (int k = NINTR; k >= 1; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NINTR) idx = idx - NINTR;
      cand = IDW'(idx);
      if (elig[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      irq_id_q  <= '0;
      ptr_q     <= IDW'(NINTR - 1);
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          irq_q   <= 1'b0;
          grant_q <= '0;
          if (|elig) begin
            irq_q    <= 1'b1;
            irq_id_q <= pick;
            grant_q  <= ONE << pick;
            cnt_q    <= '0;
            state_q  <= SERVICE;
          end
        end
        SERVICE: begin
          cnt_q <= cnt_q + 1'b1;
          if (done) begin
            irq_q   <= 1'b0;
            grant_q <= '0;
            ptr_q   <= irq_id_q;
            state_q <= RELEASE;
          end else if (tmo_hit) begin
            irq_q     <= 1'b0;
            grant_q   <= '0;
            timeout_q <= 1'b1;
            ptr_q     <= irq_id_q;
            state_q   <= RELEASE;
          end
        end
        RELEASE: begin
          irq_q   <= 1'b0;
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign grant   = grant_q;
  assign pending = pending_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_irq_rr_scheduler.sv
// Bench for irq_rr_scheduler: expected grant ids are queued by the
// stimulus and checked by a monitor on every rising edge of irq.
module tb_irq_rr_scheduler;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] req;
  logic [N-1:0] mask;
  logic         done;
  logic         irq;
  logic [1:0]   irq_id;
  logic [N-1:0] grant;
  logic [N-1:0] pending;
  logic         timeout;

  int checks;
  int errors;
  int exp_q[$];
  logic irq_prev;

  irq_rr_scheduler #(.NINTR(N), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .mask    (mask),
    .done    (done),
    .irq     (irq),
    .irq_id  (irq_id),
    .grant   (grant),
    .pending (pending),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: each new grant is compared with the head of the queue.
  always @(negedge clk) begin
    if (reset_n && irq && !irq_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected got id %0d", irq_id);
      end else begin
        int e;
        logic [N-1:0] oh;
        e  = exp_q.pop_front();
        oh = N'(1) << e;
        if (irq_id !== 2'(e) || grant !== oh) begin
          errors++;
          $display("FAIL grant_order got id %0d grant %b want id %0d grant %b",
                   irq_id, grant, e, oh);
        end
      end
    end
    irq_prev <= irq;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("wait_irq", 32'(irq), 1);
  endtask

  task automatic finish_srv();
    done = 1'b1;
    tick(1);
    done = 1'b0;
  endtask

  initial begin
    int n;
    int hi;
    checks   = 0;
    errors   = 0;
    irq_prev = 1'b0;
    reset_n  = 1'b0;
    req      = '0;
    mask     = '0;
    done     = 1'b0;
    #3;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_tmo", 32'(timeout), 0);
    tick(2);
    reset_n = 1'b1;
    mask    = 4'b1111;
    tick(1);

    // All four pulsed once: strict order 0,1,2,3 with 2-cycle gaps.
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    req = 4'b1111;
    tick(1);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      wait_irq(n);
      if (i > 0) chk("rr_gap", 32'(n), 2);
      tick(2);
      finish_srv();
    end
    tick(3);
    chk("rr_pend", 32'(pending), 0);
    chk("rr_idle", 32'(irq), 0);

    // Single request: latency and pending clear.
    exp_q.push_back(2);
    req = 4'b0100;
    tick(1);
    req = '0;
    chk("single_pend", 32'(pending), 32'h4);
    chk("single_wait", 32'(irq), 0);
    tick(1);
    chk("single_lat", 32'(irq), 1);
    finish_srv();
    chk("single_drop", 32'(irq), 0);
    chk("single_gnt0", 32'(grant), 0);
    chk("single_clr", 32'(pending), 0);
    tick(2);

    // Masked source stays pending until enabled.
    mask = 4'b1011;
    req  = 4'b0100;
    tick(1);
    req = '0;
    tick(3);
    chk("mask_pend", 32'(pending), 32'h4);
    chk("mask_noirq", 32'(irq), 0);
    exp_q.push_back(2);
    mask = 4'b1111;
    wait_irq(n);
    chk("mask_lat", 32'(n <= 2), 1);
    finish_srv();
    chk("mask_clr", 32'(pending), 0);
    tick(2);

    // Timeout: irq high 8 cycles, pulse, pending kept.
    exp_q.push_back(0);
    exp_q.push_back(1);
    req = 4'b0011;
    tick(1);
    req = '0;
    wait_irq(n);
    hi = 1;
    for (int c = 0; c < 20 && irq; c++) begin
      tick(1);
      if (irq) hi++;
    end
    chk("tmo_len", 32'(hi), 8);
    chk("tmo_pulse", 32'(timeout), 1);
    chk("tmo_pend", 32'(pending), 32'h3);
    tick(1);
    chk("tmo_once", 32'(timeout), 0);
    wait_irq(n);
    finish_srv();
    chk("tmo_after", 32'(pending), 32'h1);
    exp_q.push_back(0);
    wait_irq(n);
    finish_srv();
    chk("tmo_clr", 32'(pending), 0);
    tick(2);

    // Request on the done edge re-pends the source.
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(1);
    req = 4'b0110;
    tick(1);
    req = '0;
    wait_irq(n);
    done = 1'b1;
    req  = 4'b0010;
    tick(1);
    done = 1'b0;
    req  = '0;
    chk("setwin_pend", 32'(pending), 32'h6);
    wait_irq(n);
    finish_srv();
    wait_irq(n);
    finish_srv();
    chk("setwin_clr", 32'(pending), 0);
    tick(2);

    // Asynchronous reset in the middle of a service.
    exp_q.push_back(2);
    req = 4'b0100;
    tick(1);
    req = '0;
    wait_irq(n);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_irq", 32'(irq), 0);
    chk("arst_grant", 32'(grant), 0);
    chk("arst_pend", 32'(pending), 0);
    tick(1);
    reset_n = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(3);
    req = 4'b1001;
    tick(1);
    req = '0;
    wait_irq(n);
    finish_srv();
    wait_irq(n);
    finish_srv();
    tick(3);
    chk("end_pend", 32'(pending), 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
